// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width and field layout, route direction codes and
// default input-buffer geometry.
package noc_pkg;

   localparam int unsigned DATASIZE = 40;

   // Flit layout: src | dst | timestamp | data | type
   localparam int unsigned SRC_MSB  = 39;
   localparam int unsigned SRC_LSB  = 36;
   localparam int unsigned DST_MSB  = 35;
   localparam int unsigned DST_LSB  = 32;
   localparam int unsigned TS_MSB   = 31;
   localparam int unsigned TS_LSB   = 24;
   localparam int unsigned DATA_MSB = 23;
   localparam int unsigned DATA_LSB = 2;
   localparam int unsigned TYPE_MSB = 1;
   localparam int unsigned TYPE_LSB = 0;

   typedef enum logic [3:0] {
      DIR_LOCAL = 4'b0000,
      DIR_S     = 4'b0001,
      DIR_E     = 4'b0010,
      DIR_NONE  = 4'b1111
   } dir_e;

   localparam int unsigned DEPTH_DEF = 8;
   localparam int unsigned WIDTH_DEF = 3;

   function automatic logic [3:0] flit_dst(input logic [DATASIZE-1:0] flit);
      return flit[DST_MSB:DST_LSB];
   endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port register array: one synchronous write port, one asynchronous read port.
// Contents are not reset.
// Ports:
//   clk_i   write clock, rising edge
//   we_i    write enable
//   waddr_i write address
//   wdata_i write data
//   raddr_i read address
//   rdata_o read data (combinational from raddr_i)
module fifo_mem_2p #(
   parameter int unsigned DEPTH    = noc_pkg::DEPTH_DEF,
   parameter int unsigned WIDTH    = noc_pkg::WIDTH_DEF,
   parameter int unsigned DATASIZE = noc_pkg::DATASIZE
) (
   input  logic                clk_i,
   input  logic                we_i,
   input  logic [WIDTH-1:0]    waddr_i,
   input  logic [DATASIZE-1:0] wdata_i,
   input  logic [WIDTH-1:0]    raddr_i,
   output logic [DATASIZE-1:0] rdata_o
);

   logic [DATASIZE-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/input_buffer.sv
// Per-port input FIFO of a NoC router, between the incoming link and route computation.
// First-word fall-through: a flit pushed at an edge is presented right after it.
// Ports:
//   buf_clk      clock, rising edge
//   rst_n        asynchronous active-low reset
//   data_in      flit from upstream link
//   valid_in     upstream flit valid
//   ready_out    space available (count != DEPTH)
//   data_out     head flit, zero when empty
//   valid_out    head flit present
//   rc_ready     RC stage consumes the head flit
//   pressure_out registered occupancy 0..DEPTH
//   drop_cnt     saturating count of refused flits (only with INPUT_BUFFER_DROP_CNT_EN)
// Optional feature macro: INPUT_BUFFER_DROP_CNT_EN
module input_buffer #(
   parameter int unsigned DEPTH    = noc_pkg::DEPTH_DEF,
   parameter int unsigned WIDTH    = noc_pkg::WIDTH_DEF,
   parameter int unsigned DATASIZE = noc_pkg::DATASIZE
) (
   input  logic                buf_clk,
   input  logic                rst_n,
   input  logic [DATASIZE-1:0] data_in,
   input  logic                valid_in,
   output logic                ready_out,
   output logic [DATASIZE-1:0] data_out,
   output logic                valid_out,
   input  logic                rc_ready,
`ifdef INPUT_BUFFER_DROP_CNT_EN
   output logic [7:0]          drop_cnt,
`endif
   output logic [WIDTH:0]      pressure_out
);

   localparam logic [WIDTH:0] FullCount = (WIDTH+1)'(DEPTH);

   logic [WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
   logic [WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH:0]      count_q, count_d;
   logic                push, pop;
   logic [DATASIZE-1:0] head;

   assign ready_out = (count_q != FullCount);
   assign valid_out = (count_q != '0);
   assign push      = valid_in && ready_out;
   assign pop       = valid_out && rc_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers are log2(DEPTH) wide, so wrap is natural overflow.
      if (push) wr_ptr_d = wr_ptr_q + WIDTH'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + WIDTH'(1);
      if (push && !pop)      count_d = count_q + (WIDTH+1)'(1);
      else if (pop && !push) count_d = count_q - (WIDTH+1)'(1);
   end

   always_ff @(posedge buf_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // count_q is itself the registered occupancy.
   assign pressure_out = count_q;

   fifo_mem_2p #(
      .DEPTH    (DEPTH),
      .WIDTH    (WIDTH),
      .DATASIZE (DATASIZE)
   ) u_mem (
      .clk_i   (buf_clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (data_in),
      .raddr_i (rd_ptr_q),
      .rdata_o (head)
   );

   // Memory is not reset, so mask stale contents while empty.
   assign data_out = valid_out ? head : '0;

`ifdef INPUT_BUFFER_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (valid_in && !ready_out && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge buf_clk or negedge rst_n) begin
      if (!rst_n) drop_cnt_q <= '0;
      else        drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_input_buffer.sv
// Self-checking bench for input_buffer: a queue of expected flits is pushed when a flit
// is accepted by the model and popped when the DUT's head flit is consumed.
module tb_input_buffer;
   import noc_pkg::*;

   localparam int unsigned Depth = DEPTH_DEF;
   localparam int unsigned Width = WIDTH_DEF;

   logic                buf_clk = 1'b0;
   logic                rst_n;
   logic [DATASIZE-1:0] data_in;
   logic                valid_in;
   logic                ready_out;
   logic [DATASIZE-1:0] data_out;
   logic                valid_out;
   logic                rc_ready;
   logic [Width:0]      pressure_out;
`ifdef INPUT_BUFFER_DROP_CNT_EN
   logic [7:0]          drop_cnt;
`endif

   input_buffer #(
      .DEPTH    (Depth),
      .WIDTH    (Width),
      .DATASIZE (DATASIZE)
   ) dut (
      .buf_clk      (buf_clk),
      .rst_n        (rst_n),
      .data_in      (data_in),
      .valid_in     (valid_in),
      .ready_out    (ready_out),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .rc_ready     (rc_ready),
`ifdef INPUT_BUFFER_DROP_CNT_EN
      .drop_cnt     (drop_cnt),
`endif
      .pressure_out (pressure_out)
   );

   always #5 buf_clk = ~buf_clk;

   logic [DATASIZE-1:0] sb_q[$];
   int unsigned         drops_exp;
   int                  n_tests;
   int                  n_fail;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      check_eq("valid_out", 64'(valid_out), 64'(sb_q.size() != 0));
      check_eq("ready_out", 64'(ready_out), 64'(sb_q.size() != Depth));
      check_eq("pressure", 64'(pressure_out), 64'(sb_q.size()));
      if (sb_q.size() == 0) check_eq("data_empty", 64'(data_out), 64'd0);
      else                  check_eq("head_flit", 64'(data_out), 64'(sb_q[0]));
`ifdef INPUT_BUFFER_DROP_CNT_EN
      check_eq("drop_cnt", 64'(drop_cnt), 64'(drops_exp));
`endif
   endtask

   // One clock: drive at negedge, check outputs, then let the edge happen and update model.
   task automatic step(input logic vin, input logic [DATASIZE-1:0] din, input logic rdy);
      bit do_push, do_pop, do_drop;
      @(negedge buf_clk);
      valid_in = vin;
      data_in  = din;
      rc_ready = rdy;
      #1;
      check_outputs();
      do_pop  = (sb_q.size() != 0) && rdy;
      do_push = vin && (sb_q.size() != Depth);
      do_drop = vin && (sb_q.size() == Depth);
      @(posedge buf_clk);
      if (do_pop) void'(sb_q.pop_front());
      if (do_push) sb_q.push_back(din);
      if (do_drop && drops_exp != 255) drops_exp++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
   endtask

   task automatic drain();
      while (sb_q.size() != 0) step(1'b0, '0, 1'b1);
      idle(1);
   endtask

   function automatic logic [DATASIZE-1:0] mk_flit(input int unsigned k);
      logic [DATASIZE-1:0] f;
      f = {4'(k), 4'(k + 3), 8'(k * 7), 22'($urandom), 2'(k)};
      return f;
   endfunction

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      drops_exp = 0;
      valid_in  = 1'b0;
      data_in   = '0;
      rc_ready  = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(posedge buf_clk);
      #1;
      check_outputs();
      @(negedge buf_clk);
      rst_n = 1'b1;

      // Reset then idle.
      idle(3);

      // Single flit, first-word fall-through.
      step(1'b1, 40'h01_2345_6789, 1'b0);
      idle(1);
      check_eq("single_pressure", 64'(pressure_out), 64'd1);
      drain();

      // Fill to full, 9th flit dropped, drain in order.
      for (int i = 1; i <= 8; i++) step(1'b1, mk_flit(i), 1'b0);
      step(1'b1, mk_flit(9), 1'b0);
      idle(1);
      drain();

      // Full with simultaneous pop and valid_in: pop, drop.
      for (int i = 0; i < 8; i++) step(1'b1, mk_flit(20 + i), 1'b0);
      step(1'b1, mk_flit(99), 1'b1);
      step(1'b0, '0, 1'b0);
      check_eq("full_pop_pressure", 64'(pressure_out), 64'd7);
      check_eq("full_pop_ready", 64'(ready_out), 64'd1);
      drain();

      // Half full, streaming across pointer wrap.
      for (int i = 0; i < 4; i++) step(1'b1, mk_flit(40 + i), 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, mk_flit(50 + i), 1'b1);
         check_eq("stream_pressure", 64'(pressure_out), 64'd4);
      end
      drain();

`ifdef INPUT_BUFFER_DROP_CNT_EN
      // Saturate the drop counter.
      for (int i = 0; i < 8; i++) step(1'b1, mk_flit(80 + i), 1'b0);
      for (int i = 0; i < 300; i++) step(1'b1, mk_flit(200 + i), 1'b0);
      idle(1);
      check_eq("drop_sat", 64'(drop_cnt), 64'hFF);
      drain();
`endif

      // Reset mid-stream with 5 flits stored.
      for (int i = 0; i < 5; i++) step(1'b1, mk_flit(120 + i), 1'b0);
      @(negedge buf_clk);
      valid_in = 1'b0;
      #2;
      rst_n = 1'b0;
      sb_q.delete();
      drops_exp = 0;
      #1;
      check_eq("rst_valid", 64'(valid_out), 64'd0);
      check_eq("rst_ready", 64'(ready_out), 64'd1);
      check_eq("rst_pressure", 64'(pressure_out), 64'd0);
      check_eq("rst_data", 64'(data_out), 64'd0);
      @(negedge buf_clk);
      rst_n = 1'b1;
      idle(2);
      step(1'b1, mk_flit(7), 1'b0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
